// File: rtl/mem_arbiter.sv
// Three-port (D load/store, I fetch, X external loader) arbiter onto one single-port SRAM, with X-port lock.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; otherwise fixed priority D > I > X with I-port starvation promotion.
module mem_arbiter #(
    parameter int AW         = 14,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic          d_req,
    input  logic          x_req,
    input  logic [31:0]   i_addr,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   x_addr,
    input  logic          d_we,
    input  logic          x_we,
    input  logic [3:0]    d_be,
    input  logic [3:0]    x_be,
    input  logic [31:0]   d_wdata,
    input  logic [31:0]   x_wdata,
    input  logic          x_lock,
    output logic          i_gnt,
    output logic          d_gnt,
    output logic          x_gnt,
    output logic          i_rvalid,
    output logic          d_rvalid,
    output logic          x_rvalid,
    output logic [31:0]   i_rdata,
    output logic [31:0]   d_rdata,
    output logic [31:0]   x_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic {ARB, LOCKED} state_t;
    typedef enum logic [1:0] {PORT_D = 2'd0, PORT_I = 2'd1, PORT_X = 2'd2} port_t;

    state_t state;
    logic   rd_pend;
    port_t  rd_port;
    logic   arb_mode;
    logic   gnt_d, gnt_i, gnt_x;
    logic   any_gnt, wr;

    // A locked FSM whose x_lock has dropped already arbitrates normally in that cycle.
    assign arb_mode = (state == ARB) || !x_lock;

`ifdef MEM_ARBITER_RR_EN
    port_t ptr;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_d = 1'b0;
        gnt_i = 1'b0;
        gnt_x = 1'b0;
        if (!arb_mode) begin
            gnt_x = x_req;
        end else begin
            case (ptr)
                PORT_D: if (d_req) gnt_d = 1'b1; else if (i_req) gnt_i = 1'b1; else if (x_req) gnt_x = 1'b1;
                PORT_I: if (i_req) gnt_i = 1'b1; else if (x_req) gnt_x = 1'b1; else if (d_req) gnt_d = 1'b1;
                default: if (x_req) gnt_x = 1'b1; else if (d_req) gnt_d = 1'b1; else if (i_req) gnt_i = 1'b1;
            endcase
        end
    end

    // ptr names the port searched first; it moves past the winner on each ARB grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= PORT_D;
        end else if (arb_mode && any_gnt) begin
            ptr <= gnt_d ? PORT_I : (gnt_i ? PORT_X : PORT_D);
        end
    end
`else
    localparam logic [2:0] LIM = 3'(STARVE_LIM);
    logic [2:0] starve;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_d = 1'b0;
        gnt_i = 1'b0;
        gnt_x = 1'b0;
        if (!arb_mode)                 gnt_x = x_req;
        else if (i_req && starve == LIM) gnt_i = 1'b1;
        else if (d_req)                gnt_d = 1'b1;
        else if (i_req)                gnt_i = 1'b1;
        else if (x_req)                gnt_x = 1'b1;
    end

    // Counting pauses while locked; saturates so promotion holds until I is served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (arb_mode) begin
            if (!i_req || gnt_i)  starve <= '0;
            else if (starve != LIM) starve <= starve + 3'd1;
        end
    end
`endif

    assign any_gnt = gnt_d | gnt_i | gnt_x;
    assign wr      = (gnt_d & d_we) | (gnt_x & x_we);

    // NOTE: grants and SRAM controls are combinational, so they are gated by rst_n to read 0 during reset.
    assign d_gnt  = rst_n & gnt_d;
    assign i_gnt  = rst_n & gnt_i;
    assign x_gnt  = rst_n & gnt_x;
    assign mem_en = rst_n & any_gnt;
    assign mem_we = rst_n & wr;

    always_comb begin
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        if (rst_n) begin
            if (gnt_d) begin
                mem_addr  = d_addr[AW+1:2];
                mem_be    = d_we ? d_be : 4'hF;
                mem_wdata = d_wdata;
            end else if (gnt_i) begin
                mem_addr  = i_addr[AW+1:2];
                mem_be    = 4'hF;
            end else if (gnt_x) begin
                mem_addr  = x_addr[AW+1:2];
                mem_be    = x_we ? x_be : 4'hF;
                mem_wdata = x_wdata;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB;
            rd_pend <= 1'b0;
            rd_port <= PORT_D;
        end else begin
            rd_pend <= any_gnt && !wr;
            rd_port <= gnt_i ? PORT_I : (gnt_x ? PORT_X : PORT_D);
            if (arb_mode) state <= (gnt_x && x_lock) ? LOCKED : ARB;
        end
    end

    assign d_rvalid = rst_n & rd_pend & (rd_port == PORT_D);
    assign i_rvalid = rst_n & rd_pend & (rd_port == PORT_I);
    assign x_rvalid = rst_n & rd_pend & (rd_port == PORT_X);
    assign d_rdata  = d_rvalid ? mem_rdata : '0;
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign x_rdata  = x_rvalid ? mem_rdata : '0;

    // Byte offset and bits above the SRAM window are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0],
                                x_addr[31:AW+2], x_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural arbiter model predicts grants and read data,
// and an independent negedge monitor matches every rvalid against the queued expectation.
module tb_mem_arbiter;

    localparam int AW  = 14;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    req;              // [0]=D, [1]=I, [2]=X
    logic [31:0]   addr  [3];
    logic [2:0]    we;
    logic [3:0]    be    [3];
    logic [31:0]   wdata [3];
    logic          x_lock;

    logic          i_gnt, d_gnt, x_gnt, i_rvalid, d_rvalid, x_rvalid;
    logic [31:0]   i_rdata, d_rdata, x_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata, mem_rdata;

    mem_arbiter #(.AW(AW), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(req[1]), .d_req(req[0]), .x_req(req[2]),
        .i_addr(addr[1]), .d_addr(addr[0]), .x_addr(addr[2]),
        .d_we(we[0]), .x_we(we[2]), .d_be(be[0]), .x_be(be[2]),
        .d_wdata(wdata[0]), .x_wdata(wdata[2]), .x_lock(x_lock),
        .i_gnt(i_gnt), .d_gnt(d_gnt), .x_gnt(x_gnt),
        .i_rvalid(i_rvalid), .d_rvalid(d_rvalid), .x_rvalid(x_rvalid),
        .i_rdata(i_rdata), .d_rdata(d_rdata), .x_rdata(x_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port SRAM with one-cycle read latency.
    logic [31:0] sram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t q[$];

    logic [31:0] shadow [0:(1<<AW)-1];
    bit          m_locked;
    int          m_cnt, m_ptr;
    logic [2:0]  s_gnt;
    logic [AW-1:0] s_addr;

    task automatic idle();
        req    = '0;
        we     = '0;
        x_lock = 1'b0;
        for (int p = 0; p < 3; p++) begin
            addr[p]  = '0;
            be[p]    = 4'hF;
            wdata[p] = '0;
        end
    endtask

    // Called at posedge+1 with inputs set; checks at posedge+4, returns at next posedge+1.
    task automatic step();
        int            w;
        bit            arb;
        logic [AW-1:0] wa;
        #3;
        arb = !(m_locked && x_lock);
        w   = -1;
        if (!arb) begin
            if (req[2]) w = 2;
        end else begin
`ifdef MEM_ARBITER_RR_EN
            for (int k = 0; k < 3; k++)
                if (w < 0 && req[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
`else
            if (req[1] && m_cnt == LIM) w = 1;
            else if (req[0])            w = 0;
            else if (req[1])            w = 1;
            else if (req[2])            w = 2;
`endif
        end
        s_gnt  = {x_gnt, i_gnt, d_gnt};
        s_addr = mem_addr;
        check("gnt", s_gnt, (w < 0) ? 3'b000 : 3'(1 << w));
        check("mem_en", mem_en, w >= 0);
        if (w >= 0) begin
            wa = addr[w][AW+1:2];
            check("mem_addr", mem_addr, wa);
            check("mem_we", mem_we, (w != 1) && we[w]);
            check("mem_be", mem_be, ((w != 1) && we[w]) ? be[w] : 4'hF);
            if ((w != 1) && we[w]) begin
                check("mem_wdata", mem_wdata, wdata[w]);
                for (int b = 0; b < 4; b++)
                    if (be[w][b]) shadow[wa][8*b +: 8] = wdata[w][8*b +: 8];
            end else begin
                q.push_back('{w, shadow[wa], cyc});
            end
        end
        if (arb) begin
            m_locked = (w == 2) && x_lock;
            if (!req[1] || w == 1) m_cnt = 0;
            else if (m_cnt < LIM)  m_cnt++;
            if (w >= 0) m_ptr = (w + 1) % 3;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        q.delete();
        m_locked = 1'b0;
        m_cnt    = 0;
        m_ptr    = 0;
        idle();
        req = 3'b111;   // requests held high must still be masked during reset
        #2;
        check("rst_ctrl", |{i_gnt, d_gnt, x_gnt, i_rvalid, d_rvalid, x_rvalid, mem_en, mem_we, mem_be}, 1'b0);
        check("rst_data", |{mem_addr, mem_wdata, i_rdata, d_rdata, x_rdata}, 1'b0);
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: consume one expectation per rvalid; idle ports must show zero rdata.
    always @(negedge clk) begin
        logic [2:0]  rv;
        logic [31:0] rd [3];
        exp_t        e;
        if (rst_n) begin
            rv    = {x_rvalid, i_rvalid, d_rvalid};
            rd[0] = d_rdata;
            rd[1] = i_rdata;
            rd[2] = x_rdata;
            for (int p = 0; p < 3; p++) begin
                if (rv[p]) begin
                    if (q.size() == 0) begin
                        check("unexpected_rvalid", rv[p], 1'b0);
                    end else begin
                        e = q.pop_front();
                        check("rvalid_port", p, e.port);
                        check("rvalid_latency", cyc - 1, e.cyc);
                        check("rdata", rd[p], e.data);
                    end
                end else begin
                    check("rdata_idle", rd[p], 0);
                end
            end
            while (q.size() > 0 && q[0].cyc < cyc - 1) begin
                e = q.pop_front();
                check("missing_rvalid", rv[e.port], 1'b1);
            end
        end
    end

    initial begin
        do_reset();

        // Fill the test window through the X port so SRAM and shadow agree.
        for (int i = 0; i < 64; i++) begin
            idle();
            req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'(i * 4); wdata[2] = $urandom;
            step();
        end

        // X read of a preloaded word.
        idle(); req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'hDEADBEEF; step();
        idle(); req[2] = 1'b1; addr[2] = 32'h40; step();
        check("x_read_gnt", s_gnt, 3'b100);
        check("x_read_addr", s_addr, 14'h10);
        idle();
        check("x_read_data", {x_rvalid, x_rdata}, {1'b1, 32'hDEADBEEF});
        step();

`ifndef MEM_ARBITER_RR_EN
        // Lock: X takes the lock alone, then holds it against D until x_lock drops.
        idle(); req[2] = 1'b1; x_lock = 1'b1; step();
        check("lock_c0", s_gnt, 3'b100);
        for (int k = 1; k < 4; k++) begin
            req[0] = 1'b1;
            step();
            check("lock_held", s_gnt, 3'b100);
        end
        x_lock = 1'b0; step();
        check("lock_release", s_gnt, 3'b001);
        idle(); step();

        // Starvation: four D grants, then I promoted, repeating.
        req = 3'b011;
        for (int k = 0; k < 10; k++) begin
            step();
            check("starve_pattern", s_gnt, (k % 5 == 4) ? 3'b010 : 3'b001);
        end
        idle(); step();
`else
        do_reset();
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            step();
            check("rr_order", s_gnt, 3'(1 << (k % 3)));
        end
        idle(); step();
`endif

        // Partial write then read of the same word.
        idle(); req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h8; wdata[2] = 32'hAAAAAAAA; step();
        idle(); req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; be[0] = 4'b0011; wdata[0] = 32'h12345678; step();
        check("write_no_rvalid", d_rvalid, 1'b0);
        idle(); req[0] = 1'b1; addr[0] = 32'h8; step();
        idle();
        check("rmw_data", {d_rvalid, d_rdata}, {1'b1, 32'hAAAA5678});
        step();

        // Reset in the cycle after an I read grant: the read is discarded.
        idle(); req[1] = 1'b1; addr[1] = 32'h40; step();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_reset_idle", {i_rvalid, mem_en}, 2'b00);
        end

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            req = 3'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) begin
                addr[p]  = 32'(($urandom_range(0, 63) << 2) | ($urandom & 3));
                be[p]    = 4'($urandom);
                wdata[p] = $urandom;
            end
            we     = {1'($urandom), 1'b0, 1'($urandom)};
            x_lock = ($urandom_range(0, 7) == 0);
            step();
        end
        idle(); step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
